vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_timing.sv | 83 ++++++++
 tb/tb_vga_timing.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared 800x600@60 timing constants, count type and output bundle for the VGA timing path.
package vga_pkg;

    localparam int unsigned CNT_W = 11;

    typedef logic [CNT_W-1:0] count_t;

    // 800x600@60 with a 40 MHz pixel clock
    localparam int unsigned VGA_H_ACTIVE = 800;
    localparam int unsigned VGA_H_FP     = 40;
    localparam int unsigned VGA_H_SYNC   = 128;
    localparam int unsigned VGA_H_BP     = 88;
    localparam int unsigned VGA_V_ACTIVE = 600;
    localparam int unsigned VGA_V_FP     = 1;
    localparam int unsigned VGA_V_SYNC   = 4;
    localparam int unsigned VGA_V_BP     = 23;

    // Timing bundle handed to the downstream alignment/delay stage
    typedef struct packed {
        count_t hcount;
        count_t vcount;
        logic   hsync;
        logic   vsync;
        logic   hblnk;
        logic   vblnk;
        logic   frame_start;
    } vga_timing_t;

    // Half-open window test lo <= c < hi
    function automatic logic in_window(input count_t c, input count_t lo, input count_t hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing: horizontal/vertical counters with registered sync and blanking decode.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             hblnk,
    output logic             vblnk,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam count_t H_LAST       = CNT_W'(H_TOTAL - 1);
    localparam count_t V_LAST       = CNT_W'(V_TOTAL - 1);
    localparam count_t H_BLNK_START = CNT_W'(H_ACTIVE);
    localparam count_t H_SYNC_START = CNT_W'(H_ACTIVE + H_FP);
    localparam count_t H_SYNC_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam count_t H_END        = CNT_W'(H_TOTAL);
    localparam count_t V_BLNK_START = CNT_W'(V_ACTIVE);
    localparam count_t V_SYNC_START = CNT_W'(V_ACTIVE + V_FP);
    localparam count_t V_SYNC_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam count_t V_END        = CNT_W'(V_TOTAL);

    vga_timing_t tim_d;
    vga_timing_t tim_q;

    // Next counts, then flags decoded from those same next counts so counts and flags register together
    always_comb begin
        tim_d             = tim_q;
        tim_d.frame_start = 1'b0;   // pulse: always cleared unless this edge wraps the frame
        if (en) begin
            if (tim_q.hcount == H_LAST) begin
                tim_d.hcount = '0;
                if (tim_q.vcount == V_LAST) begin
                    tim_d.vcount      = '0;
                    tim_d.frame_start = 1'b1;
                end else begin
                    tim_d.vcount = tim_q.vcount + CNT_W'(1);
                end
            end else begin
                tim_d.hcount = tim_q.hcount + CNT_W'(1);
            end
        end
        tim_d.hblnk = in_window(tim_d.hcount, H_BLNK_START, H_END);
        tim_d.hsync = in_window(tim_d.hcount, H_SYNC_START, H_SYNC_END);
        tim_d.vblnk = in_window(tim_d.vcount, V_BLNK_START, V_END);
        tim_d.vsync = in_window(tim_d.vcount, V_SYNC_START, V_SYNC_END);
    end

    // Timing bundle register; reset lands on (0,0) with every flag low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tim_q <= '0;
        end else begin
            tim_q <= tim_d;
        end
    end

    assign hcount      = tim_q.hcount;
    assign vcount      = tim_q.vcount;
    assign hsync       = tim_q.hsync;
    assign vsync       = tim_q.vsync;
    assign hblnk       = tim_q.hblnk;
    assign vblnk       = tim_q.vblnk;
    assign frame_start = tim_q.frame_start;

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing: default 800x600 instance plus a shrunken instance for whole-frame tests.
`timescale 1ns/1ps
module tb_vga_timing;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic        fs;
    } obs_t;

    typedef struct {
        logic        en;
        int          n;
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        hb;
        logic        vs;
        logic        vb;
        logic        fs;
        string       name;
    } vec_t;

    // Small instance geometry: H 10/2/3/2 (17), V 5/1/2/2 (10)
    localparam int S_HA = 10, S_HF = 2, S_HS = 3, S_HB = 2;
    localparam int S_VA = 5,  S_VF = 1, S_VS = 2, S_VB = 2;

    logic        clk;
    logic        rst_n_a, rst_n_b, en_a, en_b;
    logic [10:0] h_a, v_a, h_b, v_b;
    logic        hs_a, vs_a, hb_a, vb_a, fs_a;
    logic        hs_b, vs_b, hb_b, vb_b, fs_b;

    int   checks = 0;
    int   errors = 0;
    int   mh[2];
    int   mv[2];
    obs_t sb_q[$];

    vga_timing u_dut_big (
        .clk(clk), .rst_n(rst_n_a), .en(en_a),
        .hcount(h_a), .vcount(v_a), .hsync(hs_a), .vsync(vs_a),
        .hblnk(hb_a), .vblnk(vb_a), .frame_start(fs_a)
    );

    vga_timing #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
    ) u_dut_small (
        .clk(clk), .rst_n(rst_n_b), .en(en_b),
        .hcount(h_b), .vcount(v_b), .hsync(hs_b), .vsync(vs_b),
        .hblnk(hb_b), .vblnk(vb_b), .frame_start(fs_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int htot(input int d);
        return (d == 0) ? 1056 : (S_HA + S_HF + S_HS + S_HB);
    endfunction

    function automatic int vtot(input int d);
        return (d == 0) ? 628 : (S_VA + S_VF + S_VS + S_VB);
    endfunction

    // Expected outputs straight from the raster ranges
    function automatic obs_t expect_of(input int d, input int h, input int v, input logic fs);
        obs_t o;
        int   ha, hf, hs, va, vf, vs;
        if (d == 0) begin
            ha = 800; hf = 40; hs = 128; va = 600; vf = 1; vs = 4;
        end else begin
            ha = S_HA; hf = S_HF; hs = S_HS; va = S_VA; vf = S_VF; vs = S_VS;
        end
        o.h  = 11'(h);
        o.v  = 11'(v);
        o.hb = (h >= ha);
        o.hs = (h >= ha + hf) && (h < ha + hf + hs);
        o.vb = (v >= va);
        o.vs = (v >= va + vf) && (v < va + vf + vs);
        o.fs = fs;
        return o;
    endfunction

    function automatic obs_t obs_of(input int d);
        obs_t o;
        if (d == 0) begin
            o.h = h_a; o.v = v_a; o.hs = hs_a; o.vs = vs_a; o.hb = hb_a; o.vb = vb_a; o.fs = fs_a;
        end else begin
            o.h = h_b; o.v = v_b; o.hs = hs_b; o.vs = vs_b; o.hb = hb_b; o.vb = vb_b; o.fs = fs_b;
        end
        return o;
    endfunction

    task automatic cmp(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b, expected h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b",
                     name, got.h, got.v, got.hs, got.vs, got.hb, got.vb, got.fs,
                     exp.h, exp.v, exp.hs, exp.vs, exp.hb, exp.vb, exp.fs);
        end
    endtask

    task automatic cmp_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Range and sync-within-blank invariants on the observed outputs
    task automatic invariants(input int d, input obs_t got);
        checks++;
        if (!(int'(got.h) < htot(d) && int'(got.v) < vtot(d) &&
              (!got.hs || got.hb) && (!got.vs || got.vb))) begin
            errors++;
            $display("FAIL invariant_dut%0d: got h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b",
                     d, got.h, got.v, got.hs, got.hb, got.vs, got.vb);
        end
    endtask

    // One clock on DUT d: advance the model, queue the expectation, clock, pop and compare
    task automatic step(input int d, input logic e, input string name, output obs_t got);
        logic fs;
        fs = 1'b0;
        if (e) begin
            if (mh[d] == htot(d) - 1) begin
                mh[d] = 0;
                if (mv[d] == vtot(d) - 1) begin
                    mv[d] = 0;
                    fs    = 1'b1;
                end else begin
                    mv[d] = mv[d] + 1;
                end
            end else begin
                mh[d] = mh[d] + 1;
            end
        end
        sb_q.push_back(expect_of(d, mh[d], mv[d], fs));
        if (d == 0) en_a = e; else en_b = e;
        @(posedge clk);
        #1;
        got = obs_of(d);
        cmp(name, got, sb_q.pop_front());
        invariants(d, got);
        if (d == 0) en_a = 1'b0; else en_b = 1'b0;
    endtask

    initial begin
        vec_t tbl[12];
        obs_t got;
        obs_t ex;
        obs_t zero;
        int   fs_cnt;
        int   vs_cnt;

        zero = '0;
        tbl[0]  = '{1'b1, 799, 11'd799,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "h_active_end"};
        tbl[1]  = '{1'b1, 1,   11'd800,  11'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "hblnk_rise"};
        tbl[2]  = '{1'b1, 39,  11'd839,  11'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "pre_hsync"};
        tbl[3]  = '{1'b1, 1,   11'd840,  11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "hsync_rise"};
        tbl[4]  = '{1'b1, 127, 11'd967,  11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "hsync_last"};
        tbl[5]  = '{1'b1, 1,   11'd968,  11'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "hsync_fall"};
        tbl[6]  = '{1'b1, 87,  11'd1055, 11'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "h_last"};
        tbl[7]  = '{1'b1, 1,   11'd0,    11'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "line_wrap"};
        tbl[8]  = '{1'b1, 500, 11'd500,  11'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "to_500"};
        tbl[9]  = '{1'b0, 10,  11'd500,  11'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "en_low_hold"};
        tbl[10] = '{1'b1, 1,   11'd501,  11'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "resume_501"};
        tbl[11] = '{1'b0, 3,   11'd501,  11'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "hold_again"};

        mh[0] = 0; mv[0] = 0; mh[1] = 0; mv[1] = 0;
        en_a = 1'b0; en_b = 1'b0;
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        #2;
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        #1;
        cmp("reset_async_big", obs_of(0), zero);
        cmp("reset_async_small", obs_of(1), zero);
        repeat (2) @(posedge clk);
        #1;
        cmp("reset_held_big", obs_of(0), zero);
        cmp("reset_held_small", obs_of(1), zero);
        rst_n_a = 1'b1; rst_n_b = 1'b1;

        // No frame_start on reset release while idle
        step(0, 1'b0, "release_idle", got);
        // Default-geometry line walk from the table
        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < tbl[i].n; k++) step(0, tbl[i].en, tbl[i].name, got);
            ex = '{tbl[i].h, tbl[i].v, tbl[i].hs, tbl[i].vs, tbl[i].hb, tbl[i].vb, tbl[i].fs};
            cmp({tbl[i].name, "_end"}, obs_of(0), ex);
        end

        // Full frame on the small instance: one frame_start, vsync for two lines
        fs_cnt = 0;
        vs_cnt = 0;
        for (int k = 0; k < 170; k++) begin
            step(1, 1'b1, "frame_run", got);
            if (got.fs) fs_cnt++;
            if (got.vs) vs_cnt++;
        end
        cmp_int("frame_start_at_wrap", int'(fs_b), 1);
        cmp_int("frame_start_pulses", fs_cnt, 1);
        cmp_int("vsync_cycles", vs_cnt, 2 * 17);
        step(1, 1'b1, "frame_start_drop", got);
        cmp_int("frame_start_one_cycle", int'(got.fs), 0);

        // Into the vsync lines (h=5, v=6), then async reset mid-cycle
        for (int k = 0; k < 106; k++) step(1, 1'b1, "to_vsync", got);
        cmp_int("pre_reset_vsync", int'(got.vs), 1);
        cmp_int("pre_reset_vcount", int'(got.v), 6);
        #3;
        rst_n_b = 1'b0;
        #1;
        cmp("midframe_async_reset", obs_of(1), zero);
        mh[1] = 0; mv[1] = 0;
        @(posedge clk);
        #1;
        cmp("midframe_reset_held", obs_of(1), zero);
        #2;
        rst_n_b = 1'b1;
        step(1, 1'b0, "post_release_idle", got);
        step(1, 1'b0, "post_release_idle", got);
        step(1, 1'b1, "first_enabled_edge", got);
        cmp_int("first_edge_hcount", int'(got.h), 1);
        for (int k = 0; k < 20; k++) step(1, 1'b1, "post_reset_run", got);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
